fifo_reader: RTL and testbench

Read-side controller for the on-chip FIFO macro. On `start` it pops exactly `len` words from the FIFO, absorbs the FIFO's one-cycle read latency, and presents the words on a valid/ready stream to the downstream datapath. Backpressure is handled by a 2-entry skid buffer, so a stalled consumer never loses data and a ready consumer gets one word per cycle. It sits between a FIFO instance (`rden`/`q`/`empty` side) and the compute or output stage.

---
 rtl/fifo_reader_pkg.sv | 15 +
 rtl/fifo_reader_if.sv | 38 +++
 rtl/fifo_reader_skid.sv | 52 +++++
 rtl/fifo_reader.sv | 122 ++++++++++++
 tb/tb_fifo_reader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader shared types and constants.
// Imported by the interface, skid buffer and top.
`timescale 1ns/1ps
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SKID_DEPTH      = 2;
  localparam int STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO-side, control and stream signals of fifo_reader.
// master = environment side, slave = fifo_reader side.
`timescale 1ns/1ps
interface fifo_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  import fifo_reader_pkg::*;

  logic                       start;
  logic [LEN_WIDTH-1:0]       len;
  logic                       busy;
  logic                       done;
  logic                       fifo_rden;
  logic [DATA_WIDTH-1:0]      fifo_rdata;
  logic                       fifo_empty;
  logic                       out_valid;
  logic [DATA_WIDTH-1:0]      out_data;
  logic                       out_ready;
  logic [STALL_CNT_WIDTH-1:0] stall_cycles;

  modport master (
    output start, len, fifo_rdata,
    output fifo_empty, out_ready,
    input  busy, done, fifo_rden,
    input  out_valid, out_data,
    input  stall_cycles
  );

  modport slave (
    input  start, len, fifo_rdata,
    input  fifo_empty, out_ready,
    output busy, done, fifo_rden,
    output out_valid, out_data,
    output stall_cycles
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order skid buffer behind the FIFO read port.
// Simultaneous write and pop leave the occupancy unchanged.
`timescale 1ns/1ps
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      unique case ({wr_en, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // A write into a full buffer without a pop means the rden gate is broken.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(wr_en && !pop && occ == 2'd2)
  );

endmodule

// File: rtl/fifo_reader.sv
// Burst read controller: pops len FIFO words onto a valid/ready stream.
// Build with FIFO_READER_STATS_EN to enable the stall_cycles counter.
`timescale 1ns/1ps
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input logic          clk,
  input logic          rst,
  fifo_reader_if.slave bus
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  localparam logic [LEN_WIDTH:0] ONE =
    (LEN_WIDTH+1)'(1);

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic [LEN_WIDTH:0]    len_q;
  logic [LEN_WIDTH:0]    issued;
  logic [LEN_WIDTH:0]    delivered;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  accept;
  logic                  pop;
  logic                  rden;
  logic                  last;
  logic [2:0]            fill;

  assign accept = (state == IDLE) && bus.start;
  assign pop    = bus.out_valid && bus.out_ready;

  // Occupancy the buffer will hold next cycle if nothing new is popped.
  assign fill = {1'b0, occ}
              + {2'b00, inflight}
              - {2'b00, pop};

  assign rden = (state == RUN)
             && !bus.fifo_empty
             && (issued < len_q)
             && (fill < 3'd2);

  assign last = pop && (delivered + ONE == len_q);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start)
              state_nx = (bus.len == '0) ? DONE : RUN;
      RUN:  if (last)
              state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      delivered <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= rden;
      if (accept) begin
        len_q     <= {1'b0, bus.len};
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (rden)
          issued <= issued + ONE;
        if (pop)
          delivered <= delivered + ONE;
      end
    end
  end

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (bus.fifo_rdata),
    .pop     (pop),
    .occ     (occ),
    .head    (head)
  );

  assign bus.fifo_rden = rden;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = head;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

`ifdef FIFO_READER_STATS_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (accept)
      stall_q <= '0;
    else if ((state == RUN) && bus.out_valid
             && !bus.out_ready && (stall_q != '1))
      stall_q <= stall_q + 1'b1;
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader against a word-count reference model.
// Covers full rate, backpressure, empty FIFO, zero length, reset and restart.
`timescale 1ns/1ps
module tb_fifo_reader;
  import fifo_reader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_reader_if #(.DATA_WIDTH(8), .LEN_WIDTH(8)) bus ();

  fifo_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  logic [7:0] pend[$];

  // Reference model: phase (0 idle, 1 run, 2 done) plus word counts.
  int m_st, m_left, m_to_pop, m_out, m_prev_r, m_stall;
  int cyc, first_rden, first_valid, done_cyc, n_hs, n_done;
  logic [7:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic [7:0] ln,
                      input logic rdy, input logic fe);
    logic ev, ep, er, r;
    logic [7:0] w;
    bus.start      = st;
    bus.len        = ln;
    bus.out_ready  = rdy;
    bus.fifo_empty = fe || (fq.size() == 0);
    #2;
    ev = (m_out - m_prev_r) > 0;
    ep = ev && rdy;
    er = (m_st == 1) && !bus.fifo_empty && (m_to_pop > 0)
         && ((m_out - (ep ? 1 : 0)) < 2);
    chk("busy", 32'(bus.busy), 32'(m_st != 0));
    chk("done", 32'(bus.done), 32'(m_st == 2));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("fifo_rden", 32'(bus.fifo_rden), 32'(er));
    if (ev)
      chk("out_data", 32'(bus.out_data),
          (pend.size() != 0) ? 32'(pend[0]) : 32'hdead);
`ifdef FIFO_READER_STATS_EN
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stall));
`else
    chk("stall_cycles", 32'(bus.stall_cycles), 32'd0);
`endif
    if (bus.fifo_rden && first_rden < 0) first_rden = cyc;
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    if (bus.done && done_cyc < 0) done_cyc = cyc;
    if (bus.done) n_done++;
    if (bus.out_valid && rdy) begin
      n_hs++;
      last_data = bus.out_data;
    end
    if (m_st == 1 && ev && !rdy && m_stall < 65535) m_stall++;
    m_out    = m_out + (er ? 1 : 0) - (ep ? 1 : 0);
    m_to_pop = m_to_pop - (er ? 1 : 0);
    m_prev_r = er ? 1 : 0;
    if (ep && pend.size() != 0) void'(pend.pop_front());
    case (m_st)
      0: if (st) begin
           m_stall  = 0;
           m_left   = ln;
           m_to_pop = ln;
           m_st     = (ln == 0) ? 2 : 1;
         end
      1: if (ep) begin
           m_left--;
           if (m_left == 0) m_st = 2;
         end
      default: m_st = 0;
    endcase
    r = bus.fifo_rden;
    @(posedge clk);
    #1;
    if (r && fq.size() != 0) begin
      w = fq.pop_front();
      bus.fifo_rdata = w;
      pend.push_back(w);
    end
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rden", 32'(bus.fifo_rden), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    m_st = 0; m_out = 0; m_prev_r = 0;
    m_stall = 0; m_to_pop = 0; m_left = 0;
    pend.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic burst(input int ln, input int rdy_pct,
                       input int lo_a, input int lo_b,
                       input int emp_until, input int emp_pct,
                       input int restart_at, input int rst_hs);
    int c;
    logic rdy, fe, st;
    logic [7:0] l;
    first_rden = -1; first_valid = -1; done_cyc = -1;
    n_hs = 0; n_done = 0; cyc = 0; c = 0;
    do begin
      rdy = ($urandom_range(99) < rdy_pct)
            && !(c >= lo_a && c <= lo_b);
      fe  = (c < emp_until) || ($urandom_range(99) < emp_pct);
      st  = (c == 0) || (c == restart_at);
      l   = (c == 0) ? 8'(ln) : 8'd9;
      step(st, l, rdy, fe);
      c++;
      if (rst_hs >= 0 && n_hs == rst_hs) begin
        do_reset();
        break;
      end
    end while (m_st != 0 && c < 2000);
    chk("idle_after_burst", 32'(bus.busy), 32'd0);
    if (rst_hs < 0) begin
      chk("handshakes", 32'(n_hs), 32'(ln));
      chk("done_pulses", 32'(n_done), 32'd1);
    end
  endtask

  task automatic load_seq(input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(8'(8'hA1 + i));
  endtask

  initial begin
    logic [7:0] expw;
    int ln;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0;
    bus.fifo_rdata = '0; bus.fifo_empty = 1'b1;
    bus.out_ready = 1'b0;
    m_st = 0; m_left = 0; m_to_pop = 0;
    m_out = 0; m_prev_r = 0; m_stall = 0;
    #3;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_rden", 32'(bus.fifo_rden), 32'd0);
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_data", 32'(bus.out_data), 32'd0);
    chk("reset_stall", 32'(bus.stall_cycles), 32'd0);
    @(posedge clk); @(posedge clk);
    #1; rst = 1'b0; #1;

    load_seq(4);
    burst(4, 100, -1, -1, 0, 0, -1, -1);
    chk("full_first_rden", 32'(first_rden), 32'd1);
    chk("full_first_valid", 32'(first_valid), 32'd3);
    chk("full_done_cycle", 32'(done_cyc), 32'd7);

    load_seq(4);
    burst(3, 100, 3, 6, 0, 0, -1, -1);
`ifdef FIFO_READER_STATS_EN
    chk("bp_stall_total", 32'(bus.stall_cycles), 32'd4);
`else
    chk("bp_stall_total", 32'(bus.stall_cycles), 32'd0);
`endif
    chk("bp_last_word", 32'(last_data), 32'hA3);

    load_seq(2);
    burst(2, 100, -1, -1, 5, 0, -1, -1);
    chk("empty_first_rden", 32'(first_rden), 32'd5);

    load_seq(2);
    burst(0, 100, -1, -1, 0, 0, -1, -1);
    chk("zero_done_cycle", 32'(done_cyc), 32'd1);
    chk("zero_no_rden", 32'(first_rden), 32'hffffffff);
    chk("zero_no_valid", 32'(first_valid), 32'hffffffff);

    load_seq(8);
    burst(4, 100, -1, -1, 0, 0, -1, 2);
    expw = fq[0];
    burst(1, 100, -1, -1, 0, 0, -1, -1);
    chk("post_rst_word", 32'(last_data), 32'(expw));

    load_seq(4);
    burst(4, 100, -1, -1, 0, 0, 2, -1);
    chk("restart_last_word", 32'(last_data), 32'hA4);

    fq.delete();
    for (int i = 0; i < 255; i++) fq.push_back(8'($urandom));
    burst(255, 100, -1, -1, 0, 0, -1, -1);
    chk("max_len_done", 32'(done_cyc), 32'd258);

    for (int k = 0; k < 15; k++) begin
      ln = int'($urandom_range(20, 1));
      fq.delete();
      for (int i = 0; i < ln; i++) fq.push_back(8'($urandom));
      burst(ln, int'($urandom_range(90, 40)), -1, -1,
            0, 25, int'($urandom_range(6, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
